d_sram_like_bridge: RTL

D_SRAM_LIKE_BRIDGE -- requirements
Module: d_sram_like_bridge

---
 rtl/d_sram_like_bridge.sv | 138 +++++++++++++
 1 files changed

// File: rtl/d_sram_like_bridge.sv
// Bridges the datapath memory-stage access onto an sram-like data bus, holding the pipeline until the access completes.
// Latency: at least 2 cycles (addr_ok in the issue cycle, data_ok the next); read data is on cpu_rdata once cpu_stall falls.
// Backpressure: data_req and its fields are held until data_addr_ok; cpu_stall stays high until data_data_ok; DONE waits out longest_stall.
//
// Ports:
//   clk, resetn                        clock, asynchronous active-low reset
//   cpu_en/cpu_wen/cpu_addr/cpu_wdata  datapath access (cpu_wen == 0 means read)
//   cpu_rdata, cpu_stall               read buffer and pipeline stall back to the datapath
//   longest_stall                      global pipeline stall; keeps the bridge in DONE
//   data_req/data_wr/data_size/data_addr/data_wdata   sram-like request
//   data_addr_ok/data_data_ok/data_rdata               sram-like acknowledges and read data
//
// Optional feature: define DBRIDGE_ADDR_MAP_EN to fold kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF)
// onto physical addresses by masking with 0x1FFF_FFFF.
module d_sram_like_bridge (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        longest_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateT;

    stateT       state;
    logic [3:0]  wenQ;
    logic [31:0] addrQ;
    logic [31:0] wdataQ;
    logic [31:0] rdataBuf;

    logic        issue;
    logic        showReq;
    logic [3:0]  reqWen;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [31:0] physAddr;
    logic [1:0]  reqSize;

    // The issue cycle is combinational: the request goes out in the same cycle cpu_en
    // is seen, so its fields come straight from the datapath. Gating with resetn keeps
    // every output quiet while reset is held, even if cpu_en is high.
    assign issue   = resetn && (state == IDLE) && cpu_en;
    assign showReq = issue || (state != IDLE);

    // After the issue cycle the latched copy is used, so the fields stay stable while
    // the slave withholds addr_ok even though the datapath inputs may change.
    assign reqWen   = issue ? cpu_wen   : wenQ;
    assign reqAddr  = issue ? cpu_addr  : addrQ;
    assign reqWdata = issue ? cpu_wdata : wdataQ;

    // Only the two aligned halfword masks are halfwords; any other multi-byte mask,
    // legal or not, goes out as a word. Reads are always full words.
    always_comb begin
        case (reqWen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: reqSize = 2'd0;
            4'b0011, 4'b1100:                   reqSize = 2'd1;
            default:                            reqSize = 2'd2;
        endcase
    end

    always_comb begin
        physAddr = reqAddr;
`ifdef DBRIDGE_ADDR_MAP_EN
        if (reqAddr[31:30] == 2'b10) begin
            physAddr = reqAddr & 32'h1FFF_FFFF;
        end
`endif
        if (reqWen == 4'b0000) begin
            physAddr[1:0] = 2'b00;
        end
    end

    assign data_req   = issue || (state == ADDR);
    assign cpu_stall  = issue || (state == ADDR) || (state == DATA);
    assign data_wr    = showReq && (|reqWen);
    assign data_size  = showReq ? reqSize  : 2'b00;
    assign data_addr  = showReq ? physAddr : 32'h0;
    assign data_wdata = showReq ? reqWdata : 32'h0;
    assign cpu_rdata  = rdataBuf;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            wenQ     <= 4'h0;
            addrQ    <= 32'h0;
            wdataQ   <= 32'h0;
            rdataBuf <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_en) begin
                        wenQ   <= cpu_wen;
                        addrQ  <= cpu_addr;
                        wdataQ <= cpu_wdata;
                        state  <= data_addr_ok ? DATA : ADDR;
                    end
                end
                // The request is committed once issued; cpu_en falling does not cancel it.
                ADDR: begin
                    if (data_addr_ok) begin
                        state <= DATA;
                    end
                end
                // data_data_ok only counts here, which also keeps it from ever being
                // taken in the same cycle as the address handshake.
                DATA: begin
                    if (data_data_ok) begin
                        if (wenQ == 4'b0000) begin
                            rdataBuf <= data_rdata;
                        end
                        state <= DONE;
                    end
                end
                // Hold off a new request until the pipeline has actually advanced,
                // otherwise the same stalled instruction would be issued twice.
                DONE: begin
                    if (!longest_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
